// File: rtl/color_round_ctrl_pkg.sv
// Shared definitions for the colour-round controller: default sizing,
// LFSR polynomial, FSM state encoding and small helper functions.
package color_round_ctrl_pkg;

    localparam int          DEF_NUM_PLATS = 4;
    localparam int          DEF_COLOR_W   = 3;
    localparam int          DEF_MAX_RETRY = 15;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRAW_BALL = 3'd1,
        ST_DRAW_POS  = 3'd2,
        ST_DRAW_PLAT = 3'd3,
        ST_COMMIT    = 3'd4
    } round_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Width of a platform index; never zero so a 1-platform build still has a bus.
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/color_round_ctrl_if.sv
// Request/result bundle between the game FSM (master) and the colour-round
// controller (slave). Renderers simply observe the result signals.
interface color_round_ctrl_if
    import color_round_ctrl_pkg::*;
#(
    parameter int NUM_PLATS = DEF_NUM_PLATS,
    parameter int COLOR_W   = DEF_COLOR_W
);
    localparam int POS_W = pos_width(NUM_PLATS);

    logic                           new_round;
    logic                           seed_load;
    logic [15:0]                    seed_in;
    logic                           busy;
    logic                           colors_valid;
    logic [NUM_PLATS*COLOR_W-1:0]   new_color_plats;
    logic [COLOR_W-1:0]             new_color_ball;
    logic [POS_W-1:0]               ball_pos;

    modport master (
        output new_round, seed_load, seed_in,
        input  busy, colors_valid, new_color_plats, new_color_ball, ball_pos
    );

    modport slave (
        input  new_round, seed_load, seed_in,
        output busy, colors_valid, new_color_plats, new_color_ball, ball_pos
    );

endinterface

// File: rtl/color_round_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR with seed load. A zero seed is replaced by
// the default seed, and a zero state (which would lock up) is re-seeded.
module lfsr16
    import color_round_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);
    logic [15:0] q_r;

    assign q = q_r;

    // LFSR state: reset/seed load, zero-lock recovery, otherwise one step per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= SEED;
        end else if (load) begin
            q_r <= (load_val == 16'h0000) ? SEED : load_val;
        end else if (q_r == 16'h0000) begin
            q_r <= SEED;
        end else begin
            q_r <= lfsr_step(q_r);
        end
    end

endmodule

// File: rtl/color_round_ctrl.sv
// Colour-round controller: on request, draws a ball colour, a target platform
// and a colour for every platform (target matches the ball, the rest differ,
// none black), then publishes the whole set in one cycle.
module color_round_ctrl
    import color_round_ctrl_pkg::*;
#(
    parameter int          NUM_PLATS = DEF_NUM_PLATS,
    parameter int          COLOR_W   = DEF_COLOR_W,
    parameter int          MAX_RETRY = DEF_MAX_RETRY,
    parameter logic [15:0] SEED      = DEF_SEED
) (
    input logic               clk,
    input logic               reset,
    color_round_ctrl_if.slave bus
);
    localparam int                 POS_W       = pos_width(NUM_PLATS);
    localparam int                 RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [POS_W-1:0]   LAST_IDX    = POS_W'(NUM_PLATS - 1);
    localparam logic [COLOR_W-1:0] BLACK_C     = {COLOR_W{1'b0}};
    localparam logic [COLOR_W-1:0] TOP_C       = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] ONE_C       = COLOR_W'(1);

    round_state_e                   state_r;
    round_state_e                   state_nx_s;

    logic [15:0]                    lfsr_q_s;
    logic [COLOR_W-1:0]             color_draw_s;
    logic [POS_W-1:0]               pos_draw_s;
    logic                           color_ok_s;
    logic [COLOR_W-1:0]             fallback_s;

    logic                           lfsr_ld_s;
    logic                           start_s;
    logic                           ball_ld_s;
    logic                           pos_ld_s;
    logic                           plat_ld_s;
    logic [COLOR_W-1:0]             plat_val_s;
    logic                           retry_inc_s;
    logic                           commit_s;

    logic [COLOR_W-1:0]             ball_sh_r;
    logic [POS_W-1:0]               pos_sh_r;
    logic [NUM_PLATS*COLOR_W-1:0]   plat_sh_r;
    logic [POS_W-1:0]               idx_r;
    logic [RETRY_W-1:0]             retry_cnt_r;

    logic                           busy_r;
    logic                           valid_r;
    logic [NUM_PLATS*COLOR_W-1:0]   plats_r;
    logic [COLOR_W-1:0]             ball_r;
    logic [POS_W-1:0]               pos_r;

    lfsr16 #(
        .SEED     (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_ld_s),
        .load_val (bus.seed_in),
        .q        (lfsr_q_s)
    );

    assign color_draw_s = lfsr_q_s[COLOR_W-1:0];
    assign pos_draw_s   = lfsr_q_s[15 -: POS_W];
    assign color_ok_s   = (color_draw_s != BLACK_C) && (color_draw_s != ball_sh_r);
    // Next colour after the ball, wrapping past black to the first real colour.
    assign fallback_s   = (ball_sh_r == TOP_C) ? ONE_C : (ball_sh_r + ONE_C);

    assign bus.busy            = busy_r;
    assign bus.colors_valid    = valid_r;
    assign bus.new_color_plats = plats_r;
    assign bus.new_color_ball  = ball_r;
    assign bus.ball_pos        = pos_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and per-state datapath strobes.
    always_comb begin
        state_nx_s  = state_r;
        lfsr_ld_s   = 1'b0;
        start_s     = 1'b0;
        ball_ld_s   = 1'b0;
        pos_ld_s    = 1'b0;
        plat_ld_s   = 1'b0;
        plat_val_s  = BLACK_C;
        retry_inc_s = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A seed load wins over a simultaneous request, which is dropped.
                if (bus.seed_load) begin
                    lfsr_ld_s = 1'b1;
                end else if (bus.new_round) begin
                    start_s    = 1'b1;
                    state_nx_s = ST_DRAW_BALL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRAW_BALL: begin
                if (color_draw_s != BLACK_C) begin
                    ball_ld_s  = 1'b1;
                    state_nx_s = ST_DRAW_POS;
                end else begin
                    state_nx_s = ST_DRAW_BALL;
                end
            end
            ST_DRAW_POS: begin
                pos_ld_s   = 1'b1;
                state_nx_s = ST_DRAW_PLAT;
            end
            ST_DRAW_PLAT: begin
                // Target slot copies the ball; an exhausted retry budget forces the fallback.
                if (idx_r == pos_sh_r) begin
                    plat_ld_s  = 1'b1;
                    plat_val_s = ball_sh_r;
                end else if (retry_cnt_r == RETRY_LIMIT) begin
                    plat_ld_s  = 1'b1;
                    plat_val_s = fallback_s;
                end else if (color_ok_s) begin
                    plat_ld_s  = 1'b1;
                    plat_val_s = color_draw_s;
                end else begin
                    retry_inc_s = 1'b1;
                end
                if (plat_ld_s && (idx_r == LAST_IDX)) begin
                    state_nx_s = ST_COMMIT;
                end else begin
                    state_nx_s = ST_DRAW_PLAT;
                end
            end
            ST_COMMIT: begin
                commit_s   = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Shadow registers, platform index and retry counter for the round in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_sh_r   <= BLACK_C;
            pos_sh_r    <= {POS_W{1'b0}};
            plat_sh_r   <= {(NUM_PLATS*COLOR_W){1'b0}};
            idx_r       <= {POS_W{1'b0}};
            retry_cnt_r <= {RETRY_W{1'b0}};
        end else begin
            if (ball_ld_s) begin
                ball_sh_r <= color_draw_s;
            end
            if (pos_ld_s) begin
                pos_sh_r <= pos_draw_s;
                idx_r    <= {POS_W{1'b0}};
            end else if (plat_ld_s && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + POS_W'(1);
            end
            if (plat_ld_s) begin
                plat_sh_r[idx_r*COLOR_W +: COLOR_W] <= plat_val_s;
                retry_cnt_r                         <= {RETRY_W{1'b0}};
            end else if (retry_inc_s) begin
                retry_cnt_r <= retry_cnt_r + RETRY_W'(1);
            end
        end
    end

    // Published outputs: change only at commit, so they stay stable while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            plats_r <= {(NUM_PLATS*COLOR_W){1'b0}};
            ball_r  <= BLACK_C;
            pos_r   <= {POS_W{1'b0}};
        end else begin
            valid_r <= commit_s;
            if (start_s) begin
                busy_r <= 1'b1;
            end else if (commit_s) begin
                busy_r <= 1'b0;
            end
            if (commit_s) begin
                plats_r <= plat_sh_r;
                ball_r  <= ball_sh_r;
                pos_r   <= pos_sh_r;
            end
        end
    end

endmodule

// File: tb/tb_color_round_ctrl.sv
// Bench for color_round_ctrl: randomized rounds predicted by a behavioural
// model of the drawing rules, checked by a scoreboard monitor each cycle.
module tb_color_round_ctrl;

    localparam int          NP     = 4;
    localparam int          CW     = 3;
    localparam int          PW     = 2;
    localparam int          MR     = 15;
    localparam logic [15:0] SEED_V = 16'hACE1;

    typedef struct packed {
        logic [CW-1:0]    ball;
        logic [PW-1:0]    pos;
        logic [NP*CW-1:0] plats;
        int               r_edge;
        int               v_edge;
        int               idx2_off;
    } exp_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    int          cyc      = 0;
    logic        rst_seen = 1'b1;
    logic [15:0] m_lfsr   = 16'h0000;
    int          checks   = 0;
    int          failures = 0;
    int          last_v   = 0;
    exp_t        sb_q[$];

    logic [NP*CW-1:0] exp_plats = '0;
    logic [CW-1:0]    exp_ball  = '0;
    logic [PW-1:0]    exp_pos   = '0;
    logic             busy_exp;
    exp_t             cur;

    color_round_ctrl_if #(.NUM_PLATS(NP), .COLOR_W(CW)) bus ();
    color_round_ctrl_if #(.NUM_PLATS(NP), .COLOR_W(CW)) bus_fb ();

    color_round_ctrl #(.NUM_PLATS(NP), .COLOR_W(CW), .MAX_RETRY(MR), .SEED(SEED_V)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    color_round_ctrl #(.NUM_PLATS(NP), .COLOR_W(CW), .MAX_RETRY(0), .SEED(SEED_V)) u_dut_fb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [CW-1:0] fb_color(input logic [CW-1:0] b);
        return (b == 3'd7) ? 3'd1 : (b + 3'd1);
    endfunction

    // Round prediction from the LFSR value at the request edge. Every clock edge
    // consumes one LFSR value; v_edge is returned as an offset from the request edge.
    function automatic exp_t predict(input logic [15:0] l0, input int max_retry);
        exp_t          e;
        logic [15:0]   l;
        logic [CW-1:0] c;
        int            t;
        int            retry;
        bit            done;
        e = '0;
        l = nxt(l0);
        t = 1;
        while (l[CW-1:0] == 3'd0) begin
            l = nxt(l);
            t++;
        end
        e.ball = l[CW-1:0];
        l = nxt(l);
        t++;
        e.pos = l[15:14];
        for (int i = 0; i < NP; i++) begin
            if (i == 2) e.idx2_off = t;
            retry = 0;
            done  = 1'b0;
            while (!done) begin
                l = nxt(l);
                t++;
                c = l[CW-1:0];
                if (i == int'(e.pos)) begin
                    e.plats[i*CW +: CW] = e.ball;
                    done = 1'b1;
                end else if (retry == max_retry) begin
                    e.plats[i*CW +: CW] = fb_color(e.ball);
                    done = 1'b1;
                end else if (c != 3'd0 && c != e.ball) begin
                    e.plats[i*CW +: CW] = c;
                    done = 1'b1;
                end else begin
                    retry++;
                end
            end
        end
        e.v_edge = t + 1;
        return e;
    endfunction

    // Cycle counter, reset history and the reference LFSR.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
        if (reset) m_lfsr <= SEED_V;
        else if (bus.seed_load) m_lfsr <= (bus.seed_in == 16'h0000) ? SEED_V : bus.seed_in;
        else m_lfsr <= nxt(m_lfsr);
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                sb_q.delete();
                exp_plats = '0;
                exp_ball  = '0;
                exp_pos   = '0;
                chk("reset_valid", 32'(bus.colors_valid), 32'd0);
                chk("reset_busy", 32'(bus.busy), 32'd0);
            end else begin
                busy_exp = (sb_q.size() > 0) && (cyc >= sb_q[0].r_edge) && (cyc < sb_q[0].v_edge);
                chk("busy", 32'(bus.busy), 32'(busy_exp));
                if (sb_q.size() > 0 && sb_q[0].v_edge == cyc) begin
                    chk("valid_pulse", 32'(bus.colors_valid), 32'd1);
                    cur       = sb_q.pop_front();
                    exp_plats = cur.plats;
                    exp_ball  = cur.ball;
                    exp_pos   = cur.pos;
                    for (int i = 0; i < NP; i++) begin
                        if (i == int'(bus.ball_pos))
                            chk("inv_target", 32'(bus.new_color_plats[i*CW +: CW]), 32'(bus.new_color_ball));
                        else
                            chk("inv_other_differs", 32'(bus.new_color_plats[i*CW +: CW] != bus.new_color_ball), 32'd1);
                        chk("inv_not_black", 32'(bus.new_color_plats[i*CW +: CW] != 3'd0), 32'd1);
                    end
                end else begin
                    chk("valid_idle", 32'(bus.colors_valid), 32'd0);
                end
            end
            chk("plats", 32'(bus.new_color_plats), 32'(exp_plats));
            chk("ball", 32'(bus.new_color_ball), 32'(exp_ball));
            chk("ball_pos", 32'(bus.ball_pos), 32'(exp_pos));
            chk("lfsr", 32'(u_dut.u_lfsr.q_r), 32'(m_lfsr));
        end
    end

    task automatic push_request(output exp_t e);
        e        = predict(m_lfsr, MR);
        e.r_edge = cyc + 1;
        e.v_edge = e.v_edge + e.r_edge;
        sb_q.push_back(e);
        last_v   = e.v_edge;
    endtask

    task automatic pulse_request();
        exp_t e;
        bus.new_round = 1'b1;
        push_request(e);
        @(negedge clk);
        bus.new_round = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < last_v) @(negedge clk);
    endtask

    task automatic seed_pulse(input logic [15:0] s, input logic with_req);
        bus.seed_load = 1'b1;
        bus.seed_in   = s;
        bus.new_round = with_req;
        @(negedge clk);
        bus.seed_load = 1'b0;
        bus.new_round = 1'b0;
    endtask

    // Stimulus.
    initial begin
        exp_t e;
        int   tgt;
        int   n;
        bus.new_round    = 1'b0;
        bus.seed_load    = 1'b0;
        bus.seed_in      = 16'h0000;
        bus_fb.new_round = 1'b0;
        bus_fb.seed_load = 1'b0;
        bus_fb.seed_in   = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_lfsr_seed", 32'(u_dut.u_lfsr.q_r), 32'(SEED_V));
        chk("reset_plats", 32'(bus.new_color_plats), 32'd0);
        reset  = 1'b0;
        last_v = cyc;

        // Zero seed restarts from the default seed.
        repeat (5) @(negedge clk);
        seed_pulse(16'h0000, 1'b0);
        pulse_request();
        wait_idle();

        // Seed load beats a simultaneous request, which is dropped.
        seed_pulse(16'($urandom_range(1, 65535)), 1'b1);
        pulse_request();

        // Back-to-back rounds with an occasional reseed.
        for (int r = 0; r < 1000; r++) begin
            wait_idle();
            if (r % 100 == 99) seed_pulse(16'($urandom), 1'b0);
            pulse_request();
        end
        wait_idle();

        // Request held high: new rounds only start from IDLE.
        for (int k = 0; k < 20; k++) begin
            bus.new_round = 1'b1;
            if (cyc >= last_v) push_request(e);
            @(negedge clk);
        end
        bus.new_round = 1'b0;
        wait_idle();

        // Reset while the third platform is being drawn aborts the round.
        bus.new_round = 1'b1;
        push_request(e);
        tgt = e.r_edge + e.idx2_off;
        @(negedge clk);
        bus.new_round = 1'b0;
        while (cyc < tgt) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        last_v = cyc;
        repeat (2) @(negedge clk);
        pulse_request();
        wait_idle();

        // Zero retry budget: every non-target platform takes the fallback colour.
        for (int k = 0; k < 20; k++) begin
            bus_fb.new_round = 1'b1;
            @(negedge clk);
            bus_fb.new_round = 1'b0;
            n = 0;
            while (bus_fb.colors_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("fb_timeout", 32'(n < 200), 32'd1);
            chk("fb_ball_not_black", 32'(bus_fb.new_color_ball != 3'd0), 32'd1);
            for (int i = 0; i < NP; i++) begin
                if (i == int'(bus_fb.ball_pos))
                    chk("fb_target", 32'(bus_fb.new_color_plats[i*CW +: CW]), 32'(bus_fb.new_color_ball));
                else
                    chk("fb_other", 32'(bus_fb.new_color_plats[i*CW +: CW]), 32'(fb_color(bus_fb.new_color_ball)));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
